probatina_example_burst_scheduler: RTL and testbench
====================================================

# probatina_example_burst_scheduler

Read-burst scheduler for the probatina RTL kernel. It accepts one transfer command (base address and byte count) and splits it into AXI4 read-address bursts of at most `C_MAX_BURST_LENGTH` beats. It limits in-flight bursts with an internal up/down credit counter and pulses `ctrl_done` once every issued burst has completed. It sits between the kernel control block and the AXI4 master read channel.

## Interface
- `C_ADDR_WIDTH`, default 64: address width.
- `C_XFER_SIZE_WIDTH`, default 32: byte-count width.
- `C_BYTES_PER_BEAT`, default 64: bytes per data beat; must be a power of two.
- `C_MAX_BURST_LENGTH`, default 16: maximum beats per burst, 1..256. `C_MAX_BURST_LENGTH*C_BYTES_PER_BEAT` must divide 4096.
- `C_MAX_OUTSTANDING`, default 16: maximum bursts in flight, at least 1.
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `ctrl_start`  in  1  start pulse; sampled only in IDLE.
- `ctrl_addr_offset`  in  `C_ADDR_WIDTH`  base byte address; aligned to `C_MAX_BURST_LENGTH*C_BYTES_PER_BEAT`.
- `ctrl_xfer_size_in_bytes`  in  `C_XFER_SIZE_WIDTH`  transfer length in bytes.
- `ctrl_done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in every state except IDLE.
- `arvalid`  out  1  AR valid.
- `arready`  in  1  AR ready.
- `araddr`  out  `C_ADDR_WIDTH`  burst byte address.
- `arlen`  out  8  burst length in beats, minus 1.
- `burst_done`  in  1  one pulse per completed burst (R last-beat handshake).
- `outstanding`  out  `$clog2(C_MAX_OUTSTANDING+1)`  bursts in flight.
- `stat_cycles`  out  32  cycles from command accept to done.
- `stat_stall_cycles`  out  32  cycles with `arvalid & ~arready`.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE with `ctrl_start`=1:
  - Capture the address.
  - Compute total beats as `ceil(size / C_BYTES_PER_BEAT)` using a shift and a remainder-OR.
  - Go to ISSUE, or to DONE if total beats = 0.
- ISSUE:
  - `arvalid` is high while bursts remain and `outstanding < C_MAX_OUTSTANDING`.
  - `arlen` = `min(remaining, C_MAX_BURST_LENGTH) - 1`.
  - On handshake (`arvalid & arready`), remaining decreases by `arlen+1` and `araddr` advances by `(arlen+1)*C_BYTES_PER_BEAT`.
  - When the last burst is accepted, go to DRAIN.
- DRAIN: when `outstanding` = 0, go to DONE.
- DONE: `ctrl_done`=1 for one cycle, then IDLE.
- Outstanding counter:
  - Increments on AR handshake.
  - Decrements on `burst_done`.
  - Both in the same cycle: unchanged.
  - `burst_done` while the counter is 0: ignored, with no underflow.
- Once `arvalid` is asserted, it is never withdrawn before handshake. `araddr` and `arlen` are held stable while `arvalid & ~arready`.
- `ctrl_start` outside IDLE is ignored.
- Reset mid-operation: return to IDLE and clear all counters. `burst_done` pulses arriving after reset are ignored via the zero floor.
- Reset values: `arvalid`, `ctrl_done`, `busy`, `outstanding`, `stat_*` = 0; `araddr` = 0; `arlen` = 0.

## Timing
- `ctrl_start` sampled at cycle N → `busy` and the first `arvalid` at N+1.
- Handshake at cycle M → next burst's `arvalid`, `araddr` and `arlen` valid at M+1. Back-to-back issue sustains one burst per cycle.
- Credit limit: a handshake that brings `outstanding` to `C_MAX_OUTSTANDING` at cycle M gives `arvalid`=0 at M+1. A `burst_done` at cycle K re-enables `arvalid` at K+1.
- `outstanding` becomes 0 at cycle K (DRAIN) → DONE and `ctrl_done` at K+1 → IDLE and `busy`=0 at K+2.
- Zero size: `ctrl_start` at N → `ctrl_done` at N+1, no `arvalid`.
- Earliest re-start is the first IDLE cycle after DONE.

## Configuration
- Macro: `PROBATINA_SCHED_STATS_EN`.
- Defined:
  - `stat_cycles` clears on command accept and counts every non-IDLE cycle, saturating at 0xFFFFFFFF.
  - `stat_stall_cycles` clears on accept and counts cycles with `arvalid & ~arready`, saturating.
  - Both hold their value in IDLE until the next accept.
- Undefined: both outputs are constant 0 and the counters are not instantiated. All other behaviour is identical.

## Test plan
- Four full bursts: addr 0x1000, size 4096, `arready`=1, `burst_done` 3 cycles after each AR → 4 bursts with `arlen`=15 at `araddr` 0x1000, 0x1400, 0x1800, 0x1C00; `ctrl_done` one cycle after `outstanding` reaches 0.
- Odd size: size 1100 (18 beats) → two bursts, `arlen`=15 at 0x0 then `arlen`=1 at 0x400.
- Zero size: `ctrl_start` at N → no `arvalid`; `ctrl_done`=1 at N+1; `busy` high only at N+1.
- Credit limit: `C_MAX_OUTSTANDING`=4, size 16384, `burst_done` withheld → exactly 4 handshakes, then `arvalid`=0. One `burst_done` → exactly one more burst.
- Backpressure and simultaneity:
  - `arready` low for 5 cycles → `araddr` and `arlen` stable.
  - Handshake coinciding with `burst_done` → `outstanding` unchanged.
  - With `PROBATINA_SCHED_STATS_EN`, `stat_stall_cycles`=5.
- Reset and ignored inputs:
  - `rst` during DRAIN with `outstanding`=3 → IDLE, all outputs 0; later `burst_done` pulses leave `outstanding`=0.
  - `ctrl_start` while `busy` → ignored.

Source files
------------

// File: rtl/probatina_example_burst_scheduler.sv
// Read-burst scheduler: splits one transfer command into AXI4 AR bursts of at
// most C_MAX_BURST_LENGTH beats, limits bursts in flight with a credit counter
// and pulses ctrl_done once every issued burst has completed.
// Optional statistics counters are built only when PROBATINA_SCHED_STATS_EN is
// defined; otherwise stat_cycles and stat_stall_cycles are tied to zero.
module probatina_example_burst_scheduler #(
    parameter int C_ADDR_WIDTH       = 64,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_BYTES_PER_BEAT   = 64,
    parameter int C_MAX_BURST_LENGTH = 16,
    parameter int C_MAX_OUTSTANDING  = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0]                    ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0]               ctrl_xfer_size_in_bytes,
    output logic                                       ctrl_done,
    output logic                                       busy,
    output logic                                       arvalid,
    input  logic                                       arready,
    output logic [C_ADDR_WIDTH-1:0]                    araddr,
    output logic [7:0]                                 arlen,
    input  logic                                       burst_done,
    output logic [$clog2(C_MAX_OUTSTANDING+1)-1:0]     outstanding,
    output logic [31:0]                                stat_cycles,
    output logic [31:0]                                stat_stall_cycles
);

    localparam int BEAT_SHIFT = $clog2(C_BYTES_PER_BEAT);
    localparam int OUT_W      = $clog2(C_MAX_OUTSTANDING + 1);
    localparam int SW         = C_XFER_SIZE_WIDTH;

    localparam logic [SW-1:0]    SIZE_REM_MASK   = SW'(C_BYTES_PER_BEAT - 1);
    localparam logic [SW-1:0]    MAX_BURST_BEATS = SW'(C_MAX_BURST_LENGTH);
    localparam logic [OUT_W-1:0] OUT_MAX         = OUT_W'(C_MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state, state_n;
    logic [C_ADDR_WIDTH-1:0] addr_q;
    logic [SW-1:0]           remaining;
    logic [SW-1:0]           total_beats;
    logic [SW-1:0]           burst_beats;
    logic                    accept;
    logic                    ar_hs;
    logic                    cnt_inc;
    logic                    cnt_dec;

    // Beat count rounds up: any leftover bytes below one beat cost a full beat.
    assign total_beats = (ctrl_xfer_size_in_bytes >> BEAT_SHIFT)
                       + SW'(|(ctrl_xfer_size_in_bytes & SIZE_REM_MASK));
    assign burst_beats = (remaining > MAX_BURST_BEATS) ? MAX_BURST_BEATS : remaining;

    assign accept  = (state == S_IDLE) && ctrl_start;
    // arvalid only drops on a handshake: remaining and the credit count can
    // only move against it through that handshake.
    assign arvalid = (state == S_ISSUE) && (remaining != '0) && (outstanding < OUT_MAX);
    assign ar_hs   = arvalid && arready;
    assign araddr  = addr_q;
    assign arlen   = (remaining != '0) ? 8'(burst_beats - SW'(1)) : 8'd0;

    // A completion with no burst in flight is dropped instead of underflowing.
    assign cnt_inc = ar_hs;
    assign cnt_dec = burst_done && (outstanding != '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_n   = state;
        busy      = 1'b1;
        ctrl_done = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (ctrl_start) begin
                    state_n = (total_beats == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ar_hs && (remaining == burst_beats)) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (outstanding == '0) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                ctrl_done = 1'b1;
                state_n   = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Burst address and remaining-beat tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            remaining <= '0;
        end else if (accept) begin
            addr_q    <= ctrl_addr_offset;
            remaining <= total_beats;
        end else if (ar_hs) begin
            addr_q    <= addr_q + (C_ADDR_WIDTH'(burst_beats) << BEAT_SHIFT);
            remaining <= remaining - burst_beats;
        end
    end

    // In-flight burst credit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else if (cnt_inc && !cnt_dec) begin
            outstanding <= outstanding + OUT_W'(1);
        end else if (!cnt_inc && cnt_dec) begin
            outstanding <= outstanding - OUT_W'(1);
        end
    end

`ifdef PROBATINA_SCHED_STATS_EN
    logic [31:0] cyc_cnt;
    logic [31:0] stall_cnt;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Busy-cycle and AR-stall counters, cleared on accept and held in IDLE.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (state != S_IDLE) begin
                cyc_cnt <= sat_inc32(cyc_cnt);
            end
            if (arvalid && !arready) begin
                stall_cnt <= sat_inc32(stall_cnt);
            end
        end
    end

    assign stat_cycles       = cyc_cnt;
    assign stat_stall_cycles = stall_cnt;
`else
    assign stat_cycles       = 32'd0;
    assign stat_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_probatina_example_burst_scheduler.sv
// Self-checking bench for probatina_example_burst_scheduler. A transaction-level
// model expands each command into its expected burst list and tracks credits,
// completion and statistics; DUT outputs are compared every cycle at negedge.
module tb_probatina_example_burst_scheduler;

    localparam int AW   = 64;
    localparam int SW   = 32;
    localparam int BPB  = 64;
    localparam int MAXB = 16;
    localparam int MAXO = 4;
    localparam int OW   = $clog2(MAXO + 1);

    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_FIN  = 2;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
    } burst_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ctrl_start;
    logic [AW-1:0] ctrl_addr_offset;
    logic [SW-1:0] ctrl_xfer_size_in_bytes;
    logic          ctrl_done;
    logic          busy;
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic          burst_done;
    logic [OW-1:0] outstanding;
    logic [31:0]   stat_cycles;
    logic [31:0]   stat_stall_cycles;

    always #5 clk = ~clk;

    probatina_example_burst_scheduler #(
        .C_ADDR_WIDTH       (AW),
        .C_XFER_SIZE_WIDTH  (SW),
        .C_BYTES_PER_BEAT   (BPB),
        .C_MAX_BURST_LENGTH (MAXB),
        .C_MAX_OUTSTANDING  (MAXO)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .ctrl_start              (ctrl_start),
        .ctrl_addr_offset        (ctrl_addr_offset),
        .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
        .ctrl_done               (ctrl_done),
        .busy                    (busy),
        .arvalid                 (arvalid),
        .arready                 (arready),
        .araddr                  (araddr),
        .arlen                   (arlen),
        .burst_done              (burst_done),
        .outstanding             (outstanding),
        .stat_cycles             (stat_cycles),
        .stat_stall_cycles       (stat_stall_cycles)
    );

    // Reference model state
    burst_t      bq[$];
    burst_t      hs_log[$];
    int          ph;
    int          n_out;
    int unsigned st_cyc;
    int unsigned st_stall;
    int          cyc;
    bit          pend[int];
    int          rdy_mode;
    int          bd_mode;
    bit          bd_once;
    bit          checking;
    logic [63:0] cmd_addr;
    logic [31:0] cmd_size;
    int          n_checks;
    int          n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic build_bursts(input logic [63:0] a0, input logic [31:0] size);
        logic [63:0] beats;
        logic [63:0] a;
        logic [63:0] n;
        beats = (64'(size) + 64'(BPB - 1)) / 64'(BPB);
        a     = a0;
        while (beats != 0) begin
            n = (beats > 64'(MAXB)) ? 64'(MAXB) : beats;
            bq.push_back({a, 8'(n - 1)});
            a     = a + n * 64'(BPB);
            beats = beats - n;
        end
    endtask

    // One clock: check outputs, drive inputs for the next edge, advance model.
    task automatic tick(input bit start, input bit rst_i);
        bit exp_v;
        bit rdy;
        bit bd;
        bit hs;
        int n_next;
        @(negedge clk);
        exp_v = (ph == PH_RUN) && (bq.size() > 0) && (n_out < MAXO);
        if (checking) begin
            chk("arvalid", arvalid, exp_v);
            if (exp_v) begin
                chk("araddr", araddr, bq[0].addr);
                chk("arlen", arlen, bq[0].len);
            end
            chk("busy", busy, ph != PH_IDLE);
            chk("ctrl_done", ctrl_done, ph == PH_FIN);
            chk("outstanding", outstanding, n_out);
`ifdef PROBATINA_SCHED_STATS_EN
            chk("stat_cycles", stat_cycles, st_cyc);
            chk("stat_stall", stat_stall_cycles, st_stall);
`else
            chk("stat_cycles_off", stat_cycles, 0);
            chk("stat_stall_off", stat_stall_cycles, 0);
`endif
        end
        case (rdy_mode)
            0:       rdy = 1'b0;
            1:       rdy = 1'b1;
            default: rdy = ($urandom_range(0, 3) != 0);
        endcase
        bd = bd_once || pend.exists(cyc);
        if (bd_mode == 2) bd = bd || ($urandom_range(0, 3) == 0);
        bd_once = 1'b0;
        if (pend.exists(cyc)) pend.delete(cyc);
        rst                     = rst_i;
        ctrl_start              = start;
        ctrl_addr_offset        = cmd_addr;
        ctrl_xfer_size_in_bytes = cmd_size;
        arready                 = rdy;
        burst_done              = bd;
        hs = exp_v && rdy;
        if (rst_i) begin
            ph       = PH_IDLE;
            bq.delete();
            n_out    = 0;
            st_cyc   = 0;
            st_stall = 0;
            pend.delete();
            checking = 1'b1;
        end else begin
            if (ph != PH_IDLE && st_cyc != 32'hFFFF_FFFF) st_cyc++;
            if (exp_v && !rdy) st_stall++;
            n_next = n_out + (hs ? 1 : 0) - ((bd && n_out > 0) ? 1 : 0);
            case (ph)
                PH_IDLE: begin
                    if (start) begin
                        st_cyc   = 0;
                        st_stall = 0;
                        build_bursts(cmd_addr, cmd_size);
                        ph = (bq.size() == 0) ? PH_FIN : PH_RUN;
                    end
                end
                PH_RUN: begin
                    if (bq.size() == 0) begin
                        if (n_out == 0) ph = PH_FIN;
                    end else if (hs) begin
                        hs_log.push_back(bq[0]);
                        void'(bq.pop_front());
                        if (bd_mode == 1) pend[cyc + 3] = 1'b1;
                    end
                end
                default: ph = PH_IDLE;
            endcase
            n_out = n_next;
        end
        cyc++;
    endtask

    task automatic run_until_idle(input int max_cycles, input bit spur);
        for (int i = 0; i < max_cycles && ph != PH_IDLE; i++) begin
            tick(spur && ($urandom_range(0, 7) == 0), 1'b0);
        end
        chk("run_timeout", ph == PH_IDLE, 1'b1);
        tick(1'b0, 1'b0);
        chk("end_idle", busy, 1'b0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; checking = 1'b0;
        ph = PH_IDLE; n_out = 0; st_cyc = 0; st_stall = 0; bd_once = 1'b0;
        rdy_mode = 1; bd_mode = 0;
        cmd_addr = '0; cmd_size = '0;
        rst = 1'b1; ctrl_start = 1'b0; ctrl_addr_offset = '0;
        ctrl_xfer_size_in_bytes = '0; arready = 1'b0; burst_done = 1'b0;

        // Reset state
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 0);
        chk("rst_arvalid", arvalid, 0);
        tick(1'b0, 1'b0);

        // Four full bursts, completion 3 cycles after each AR
        cmd_addr = 64'h1000; cmd_size = 4096; rdy_mode = 1; bd_mode = 1;
        hs_log.delete();
        tick(1'b1, 1'b0);
        run_until_idle(200, 1'b0);
        chk("full_nbursts", hs_log.size(), 4);
        if (hs_log.size() == 4) begin
            chk("full_addr0", hs_log[0].addr, 64'h1000);
            chk("full_addr1", hs_log[1].addr, 64'h1400);
            chk("full_addr2", hs_log[2].addr, 64'h1800);
            chk("full_addr3", hs_log[3].addr, 64'h1C00);
            for (int i = 0; i < 4; i++) chk("full_len", hs_log[i].len, 15);
        end

        // Odd size: 1100 bytes is 18 beats
        cmd_addr = 64'h0; cmd_size = 1100; rdy_mode = 2; bd_mode = 2;
        hs_log.delete();
        tick(1'b1, 1'b0);
        run_until_idle(300, 1'b0);
        chk("odd_nbursts", hs_log.size(), 2);
        if (hs_log.size() == 2) begin
            chk("odd_addr0", hs_log[0].addr, 64'h0);
            chk("odd_len0", hs_log[0].len, 15);
            chk("odd_addr1", hs_log[1].addr, 64'h400);
            chk("odd_len1", hs_log[1].len, 1);
        end

        // Zero size
        cmd_addr = 64'h2000; cmd_size = 0; rdy_mode = 1; bd_mode = 0;
        hs_log.delete();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("zero_done", ctrl_done, 1);
        chk("zero_busy", busy, 1);
        tick(1'b0, 1'b0);
        chk("zero_busy_after", busy, 0);
        chk("zero_nbursts", hs_log.size(), 0);

        // Credit limit with completions withheld; ignored start while busy
        cmd_addr = 64'h4000; cmd_size = 16384; rdy_mode = 1; bd_mode = 0;
        hs_log.delete();
        tick(1'b1, 1'b0);
        repeat (4) tick(1'b0, 1'b0);
        cmd_addr = 64'h9000; cmd_size = 64;
        tick(1'b1, 1'b0);
        repeat (5) tick(1'b0, 1'b0);
        chk("credit_hs4", hs_log.size(), 4);
        chk("credit_arvalid", arvalid, 0);
        chk("credit_out", outstanding, 4);
        bd_once = 1'b1;
        repeat (6) tick(1'b0, 1'b0);
        chk("credit_hs5", hs_log.size(), 5);
        rdy_mode = 2; bd_mode = 2;
        run_until_idle(2000, 1'b1);
        chk("credit_nbursts", hs_log.size(), 16);
        if (hs_log.size() == 16) chk("credit_last", hs_log[15].addr, 64'h7C00);

        // Backpressure for 5 cycles, then handshake coinciding with burst_done
        cmd_addr = 64'h8000; cmd_size = 4096; rdy_mode = 0; bd_mode = 0;
        tick(1'b1, 1'b0);
        repeat (5) tick(1'b0, 1'b0);
        rdy_mode = 1;
        tick(1'b0, 1'b0);
        bd_once = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("simul_out", outstanding, 1);
        bd_mode = 2;
        run_until_idle(500, 1'b0);
`ifdef PROBATINA_SCHED_STATS_EN
        chk("stall_stat5", stat_stall_cycles, 5);
`else
        chk("stall_stat_off", stat_stall_cycles, 0);
`endif

        // Reset during DRAIN with three bursts outstanding
        cmd_addr = 64'hC000; cmd_size = 3072; rdy_mode = 1; bd_mode = 0;
        tick(1'b1, 1'b0);
        repeat (5) tick(1'b0, 1'b0);
        chk("drain_out", outstanding, 3);
        chk("drain_busy", busy, 1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        chk("mrst_busy", busy, 0);
        chk("mrst_out", outstanding, 0);
        chk("mrst_araddr", araddr, 0);
        chk("mrst_arlen", arlen, 0);
        chk("mrst_done", ctrl_done, 0);
        repeat (3) begin
            bd_once = 1'b1;
            tick(1'b0, 1'b0);
        end
        tick(1'b0, 1'b0);
        chk("mrst_floor", outstanding, 0);

        // Randomized commands with random ready, completions and spurious starts
        rdy_mode = 2; bd_mode = 2;
        for (int t = 0; t < 25; t++) begin
            cmd_addr = 64'($urandom_range(0, 255)) * 64'h400;
            cmd_size = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 1) * 63)
                                                   : 32'($urandom_range(1, 12000));
            tick(1'b1, 1'b0);
            run_until_idle(3000, 1'b1);
            repeat ($urandom_range(0, 2)) tick(1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
